lnrv_flush_ctrl: RTL
====================

# lnrv_flush_ctrl

Pipeline redirect controller that sits directly downstream of the execute-stage branch unit. It accepts flush requests (two PC operands) from the branch unit and trap requests from the trap logic, then computes and registers the redirect target. It holds younger pipeline stages killed and presents the target to the IFU until the IFU accepts it. It also keeps a count of completed redirects.

## Interface
- `C_EXT`, default 1: 1 clears target bit 0 only; 0 clears target bits [1:0].
- `CNT_W`, default 32: width of the redirect counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous reset, active-low; one clock; reset is synchronous and active-low.
- `pipe_flush_req`  in  1  branch-unit flush request.
- `pipe_flush_ack`  out  1  flush accepted this cycle (combinational).
- `pipe_flush_pc_op1`  in  32  target operand 1.
- `pipe_flush_pc_op2`  in  32  target operand 2.
- `trap_req`  in  1  trap redirect request.
- `trap_pc`  in  32  trap vector target (used as-is, masked per `C_EXT`).
- `trap_ack`  out  1  trap accepted this cycle (combinational).
- `ifu_flush_vld`  out  1  redirect valid to IFU.
- `ifu_flush_rdy`  in  1  IFU accepts redirect.
- `ifu_flush_pc`  out  32  registered redirect target.
- `pipe_kill`  out  1  squash IFU/IDU/dispatch contents.
- `redirect_cnt`  out  CNT_W  completed redirect count.

## Operation
- FSM has two states. IDLE is the reset state; WAIT waits for the IFU handshake.
- Target computation:
  - Flush target = (`pipe_flush_pc_op1` + `pipe_flush_pc_op2`) mod 2^32. Carry out is discarded.
  - Then mask: bit 0 is cleared if `C_EXT`=1; bits [1:0] are cleared if `C_EXT`=0.
  - Trap target = `trap_pc` with the same mask.
- Accept condition: `can_accept` = IDLE, or WAIT with `ifu_flush_vld & ifu_flush_rdy` this cycle.
- Arbitration when `can_accept` is true:
  - `trap_req` has priority: `trap_ack`=1 and `pipe_flush_ack`=0.
  - Otherwise, `pipe_flush_req` gets `pipe_flush_ack`=1.
  - Both acks are 0 whenever `can_accept` is false.
- On accept:
  - The selected target is latched into `ifu_flush_pc`.
  - The next state is WAIT.
- On IFU handshake with no new accept in the same cycle, the next state is IDLE.
- `ifu_flush_vld` = (state==WAIT). `pipe_kill` = (state==WAIT).
- `ifu_flush_pc` must stay stable while `ifu_flush_vld`=1 and `ifu_flush_rdy`=0.
- `redirect_cnt` increments by 1 on every IFU handshake. It wraps from 2^CNT_W−1 to 0.
- Reset values:
  - State = IDLE.
  - `ifu_flush_vld`=0, `pipe_kill`=0, `ifu_flush_pc`=0, `redirect_cnt`=0.
  - Acks evaluate to 0 unless a req is present in IDLE.

## Timing
- Request at cycle N in IDLE:
  - ack=1 in cycle N.
  - At the N+1 edge, `ifu_flush_vld`=1 and `pipe_kill`=1, with `ifu_flush_pc` valid.
  - Minimum request-to-IFU latency is 1 cycle.
- IFU handshake at cycle M with no new request: `ifu_flush_vld`=0 and `pipe_kill`=0 from M+1.
- IFU handshake at cycle M with a new request present:
  - The new request is acked in M.
  - WAIT continues, and `ifu_flush_pc` holds the new target from M+1, with no bubble.
  - The counter still increments.
- A request held high while in WAIT without a handshake is not acked. The requester must hold req and operands stable until ack.
- `reset_n`=0 in any cycle, including mid-WAIT:
  - At the next edge all state returns to reset values. The pending redirect is dropped.
  - Acks are forced to 0 while `reset_n`=0.

## Test plan
- Flush add and mask:
  - Stimulus: IDLE, `pipe_flush_req`=1, op1=0x0000_1000, op2=0x0000_0011, `C_EXT`=1.
  - Response: ack=1 same cycle; next cycle `ifu_flush_vld`=1, `ifu_flush_pc`=0x0000_1010, `pipe_kill`=1.
  - Then: `ifu_flush_rdy`=1 → IDLE next cycle, `redirect_cnt`=1.
- Wrap-around sum and `C_EXT`=0 mask:
  - Stimulus: op1=0xFFFF_FFF0, op2=0x0000_0016, `C_EXT`=0.
  - Response: `ifu_flush_pc`=0x0000_0004.
- Trap priority:
  - Stimulus: same cycle, `trap_req`=1 with `trap_pc`=0x8000_0101, and `pipe_flush_req`=1.
  - Response: `trap_ack`=1, `pipe_flush_ack`=0, `ifu_flush_pc`=0x8000_0100.
  - Then: the flush request is acked in the cycle the trap's IFU handshake completes.
- IFU backpressure:
  - Stimulus: `ifu_flush_rdy`=0 for 5 cycles while a new `pipe_flush_req` is asserted.
  - Response: `ifu_flush_vld` and `pipe_kill` held high; `ifu_flush_pc` unchanged; `pipe_flush_ack`=0 for all 5 cycles.
  - Then: `ifu_flush_rdy`=1 → new request acked that cycle, new target next cycle, `redirect_cnt`=+1.
- Reset mid-WAIT:
  - Stimulus: `reset_n`=0 for one cycle while in WAIT with `redirect_cnt`=7.
  - Response: next cycle `ifu_flush_vld`=0, `pipe_kill`=0, `ifu_flush_pc`=0, `redirect_cnt`=0.
- Counter wrap:
  - Stimulus: `CNT_W`=4, 17 completed redirects.
  - Response: `redirect_cnt`=1.

Source files
------------

// File: rtl/lnrv_flush_ctrl.sv
// -----------------------------------------------------------------------------
// lnrv_flush_ctrl
//
// Pipeline redirect controller placed right after the execute-stage branch
// unit. It accepts a flush request (target = op1 + op2) or a trap request
// (target = trap_pc), masks the target to instruction alignment, registers it
// and presents it to the IFU. While the redirect is outstanding the younger
// pipeline stages are held killed. A free-running counter tallies completed
// IFU redirect handshakes.
//
// Handshake semantics (all interfaces on this block):
//   A transfer happens in a cycle where the producer's valid/req and the
//   consumer's ready/ack are both high at the rising edge. A producer must
//   hold valid/req and its payload stable until the transfer. The ack outputs
//   here are combinational and only ever rise when this block can take a new
//   redirect. ifu_flush_pc is held stable while ifu_flush_vld=1 and
//   ifu_flush_rdy=0.
//
// Parameters:
//   C_EXT  1: clear target bit 0 (16-bit instructions allowed)
//          0: clear target bits [1:0]
//   CNT_W  width of redirect_cnt
//
// Ports:
//   clk                 clock, rising edge
//   reset_n             synchronous active-low reset
//   pipe_flush_req      branch-unit flush request
//   pipe_flush_ack      flush accepted this cycle (combinational)
//   pipe_flush_pc_op1   flush target operand 1
//   pipe_flush_pc_op2   flush target operand 2
//   trap_req            trap redirect request (wins over flush)
//   trap_pc             trap vector target
//   trap_ack            trap accepted this cycle (combinational)
//   ifu_flush_vld       redirect valid to IFU
//   ifu_flush_rdy       IFU accepts redirect
//   ifu_flush_pc        registered redirect target
//   pipe_kill           squash IFU/IDU/dispatch contents
//   redirect_cnt        completed redirect count (wraps)
//   dbg_state_o         current FSM state (0 = IDLE, 1 = WAIT)
// -----------------------------------------------------------------------------
module lnrv_flush_ctrl #(
  parameter int C_EXT = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pipe_flush_req,
  output logic             pipe_flush_ack,
  input  logic [31:0]      pipe_flush_pc_op1,
  input  logic [31:0]      pipe_flush_pc_op2,
  input  logic             trap_req,
  input  logic [31:0]      trap_pc,
  output logic             trap_ack,
  output logic             ifu_flush_vld,
  input  logic             ifu_flush_rdy,
  output logic [31:0]      ifu_flush_pc,
  output logic             pipe_kill,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic             dbg_state_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Alignment mask applied to every redirect target.
  localparam logic [31:0] PC_MASK = (C_EXT != 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               ifu_hs;
  logic               can_accept;
  logic               accept;
  logic [31:0]        flush_tgt;
  logic [31:0]        sel_tgt;

  // ---------------------------------------------------------------------------
  // Shared handshake/accept terms
  // ---------------------------------------------------------------------------
  // The IFU handshake frees the target register in the same cycle, so a new
  // request can be taken back-to-back without a bubble. Reset blocks any
  // accept so that nothing is acked in a cycle whose effect will be dropped.
  assign ifu_hs     = (state_q == ST_WAIT) && ifu_flush_rdy;
  assign can_accept = reset_n && ((state_q == ST_IDLE) || ifu_hs);
  assign accept     = can_accept && (trap_req || pipe_flush_req);

  // Carry out of the 32-bit add is intentionally discarded.
  assign flush_tgt = pipe_flush_pc_op1 + pipe_flush_pc_op2;
  assign sel_tgt   = (trap_req ? trap_pc : flush_tgt) & PC_MASK;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A new accept in the handshake cycle keeps us in WAIT.
        if (accept)      state_d = ST_WAIT;
        else if (ifu_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    trap_ack       = 1'b0;
    pipe_flush_ack = 1'b0;
    ifu_flush_vld  = 1'b0;
    pipe_kill      = 1'b0;
    if (can_accept) begin
      trap_ack       = trap_req;
      pipe_flush_ack = pipe_flush_req && !trap_req;
    end
    if (state_q == ST_WAIT) begin
      ifu_flush_vld = 1'b1;
      pipe_kill     = 1'b1;
    end
  end

  assign dbg_state_o = state_q;

  // ---------------------------------------------------------------------------
  // Datapath: target register and redirect counter
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    if (accept) pc_d  = sel_tgt;
    if (ifu_hs) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q  <= 32'h0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign ifu_flush_pc = pc_q;
  assign redirect_cnt = cnt_q;

endmodule
